// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (I) and data load/store (D)
// share a single memory port with fixed read latency MEM_LAT.
// D has priority unless I has been passed over STARVE_MAX times in a row.
// Only one read is outstanding at a time; a new grant may issue in the
// response cycle of the previous read.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    // instruction port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_funct3,
    input  logic [DATA_W-1:0] m_rdata,
    // control / status
    input  logic              flush,
    output logic              busy
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [2:0] CNT_INIT   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    owner_t            r_owner;
    logic [2:0]        r_cnt;
    logic [3:0]        r_starve;
    logic              r_kill;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_arb;
    logic w_resp;
    logic w_i_win;
    logic w_d_win;
    logic w_rd_grant;

    // Arbitration window: IDLE, or the response cycle of the current read.
    assign w_arb      = !reset && (r_state == IDLE || r_cnt == 3'd0);
    assign w_resp     = !reset && r_state == BUSY && r_cnt == 3'd0;
    assign w_i_win    = w_arb && i_req && (!d_req || r_starve == STARVE_LIM);
    assign w_d_win    = w_arb && d_req && !w_i_win;
    assign w_rd_grant = w_i_win || (w_d_win && !d_we);

    assign i_gnt = w_i_win;
    assign d_gnt = w_d_win;
    assign busy  = (r_state == BUSY);

    // Memory request mux: winner's payload; fetches are always word reads.
    always_comb begin
        m_req    = w_i_win || w_d_win;
        m_we     = 1'b0;
        m_addr   = d_addr;
        m_wdata  = d_wdata;
        m_funct3 = d_funct3;
        if (w_i_win) begin
            m_addr   = i_addr;
            m_funct3 = 3'b010;
        end else if (w_d_win) begin
            m_we = d_we;
        end
    end

    // A flush seen in the response cycle itself also suppresses the fetch.
    assign i_rvalid = w_resp && r_owner == OWN_I && !r_kill && !flush;
    assign d_rvalid = w_resp && r_owner == OWN_D;
    assign i_rdata  = i_rvalid ? m_rdata : r_i_rdata;
    assign d_rdata  = d_rvalid ? m_rdata : r_d_rdata;

    // FSM, latency counter, owner/kill tracking, starve counter, rdata hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_I;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_kill    <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_i_win || !i_req)
                r_starve <= '0;
            else if (w_d_win && r_starve != STARVE_LIM)
                r_starve <= r_starve + 4'd1;

            if (i_rvalid) r_i_rdata <= m_rdata;
            if (d_rvalid) r_d_rdata <= m_rdata;

            if (w_rd_grant) begin
                r_state <= BUSY;
                r_cnt   <= CNT_INIT;
                r_owner <= w_i_win ? OWN_I : OWN_D;
                r_kill  <= w_i_win && flush;
            end else if (r_state == BUSY) begin
                if (r_cnt == 3'd0) begin
                    r_state <= IDLE;
                    r_kill  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 3'd1;
                    if (flush && r_owner == OWN_I) r_kill <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (MEM_LAT=1, STARVE_MAX=3) with a read
// scoreboard, instance B (MEM_LAT=3) for flush and reset-abort scenarios.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] pat(input logic [8:0] a);
        return 32'hC0DE_0000 | {23'd0, a};
    endfunction

    // ---------------- instance A ----------------
    logic        a_reset = 1'b1, a_flush = 1'b0;
    logic        a_i_req = 1'b0, a_d_req = 1'b0, a_d_we = 1'b0;
    logic [8:0]  a_i_addr = '0, a_d_addr = '0;
    logic [31:0] a_d_wdata = '0;
    logic [2:0]  a_d_funct3 = 3'b010;
    logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid, a_m_req, a_m_we, a_busy;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_wdata, a_m_rdata;
    logic [8:0]  a_m_addr;
    logic [2:0]  a_m_funct3;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut_a (
        .clk(clk), .reset(a_reset),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt),
        .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_funct3(a_d_funct3), .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_funct3(a_m_funct3), .m_rdata(a_m_rdata),
        .flush(a_flush), .busy(a_busy)
    );

    // ---------------- instance B ----------------
    logic        b_reset = 1'b1, b_flush = 1'b0;
    logic        b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [8:0]  b_i_addr = '0, b_d_addr = '0;
    logic [31:0] b_d_wdata = '0;
    logic [2:0]  b_d_funct3 = 3'b010;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_m_req, b_m_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
    logic [8:0]  b_m_addr;
    logic [2:0]  b_m_funct3;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) dut_b (
        .clk(clk), .reset(b_reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt),
        .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_funct3(b_d_funct3), .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_funct3(b_m_funct3), .m_rdata(b_m_rdata),
        .flush(b_flush), .busy(b_busy)
    );

    // Memory models: valid data only exactly MEM_LAT cycles after the read.
    logic [8:0] a_last = '0, b_last = '0;
    logic [2:0] a_age = '0, b_age = '0;
    always @(posedge clk) begin
        if (a_m_req && !a_m_we) begin a_last <= a_m_addr; a_age <= 3'd1; end
        else if (a_age != 3'd0 && a_age != 3'd7) a_age <= a_age + 3'd1;
        if (b_m_req && !b_m_we) begin b_last <= b_m_addr; b_age <= 3'd1; end
        else if (b_age != 3'd0 && b_age != 3'd7) b_age <= b_age + 3'd1;
    end
    assign a_m_rdata = (a_age == 3'd1) ? pat(a_last) : (32'hBAD0_0000 | {29'd0, a_age});
    assign b_m_rdata = (b_age == 3'd3) ? pat(b_last) : (32'hBAD0_0000 | {29'd0, b_age});

    // Scoreboard monitor for instance A read responses.
    always @(negedge clk) begin
        if (!a_reset && (a_i_rvalid || a_d_rvalid)) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: i_rvalid=%0b d_rvalid=%0b, expected no response", a_i_rvalid, a_d_rvalid);
            end else begin
                e = sb.pop_front();
                if ((a_i_rvalid && a_d_rvalid) || (a_d_rvalid !== e.is_d) ||
                    ((e.is_d ? a_d_rdata : a_i_rdata) !== e.data)) begin
                    errors++;
                    $display("FAIL sb_resp: i_rv=%0b d_rv=%0b i_rdata=%h d_rdata=%h, expected is_d=%0b data=%h",
                             a_i_rvalid, a_d_rvalid, a_i_rdata, a_d_rdata, e.is_d, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        a_i_req = 1'b1; a_d_req = 1'b1;
        repeat (2) begin
            tick();
            @(negedge clk);
            checks++;
            if ({a_i_gnt, a_d_gnt, a_m_req, a_i_rvalid, a_d_rvalid, a_busy} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: gnt/mreq/rvalid/busy=%b, expected 000000",
                         {a_i_gnt, a_d_gnt, a_m_req, a_i_rvalid, a_d_rvalid, a_busy});
            end
        end
        checks++;
        if (a_i_rdata !== 32'd0 || a_d_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, expected 0", a_i_rdata, a_d_rdata);
        end
        tick();
        a_reset = 1'b0; b_reset = 1'b0;
        a_i_req = 1'b0; a_d_req = 1'b0;
    endtask

    task automatic test_single_fetch();
        tick();
        a_i_req = 1'b1; a_i_addr = 9'h004;
        sb.push_back('{1'b0, pat(9'h004)});
        @(negedge clk);
        checks++;
        if (a_i_gnt !== 1'b1 || a_d_gnt !== 1'b0 || a_m_req !== 1'b1 || a_m_addr !== 9'h004 ||
            a_m_we !== 1'b0 || a_m_funct3 !== 3'b010 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_issue: i_gnt=%b m_req=%b m_addr=%h m_we=%b f3=%b busy=%b, expected 1 1 004 0 010 0",
                     a_i_gnt, a_m_req, a_m_addr, a_m_we, a_m_funct3, a_busy);
        end
        tick();
        a_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_i_rvalid !== 1'b1 || a_i_rdata !== pat(9'h004)) begin
            errors++;
            $display("FAIL fetch_resp: busy=%b i_rvalid=%b i_rdata=%h, expected 1 1 %h",
                     a_busy, a_i_rvalid, a_i_rdata, pat(9'h004));
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_i_rvalid !== 1'b0 || a_i_rdata !== pat(9'h004)) begin
            errors++;
            $display("FAIL fetch_hold: busy=%b i_rvalid=%b i_rdata=%h, expected 0 0 %h",
                     a_busy, a_i_rvalid, a_i_rdata, pat(9'h004));
        end
    endtask

    task automatic test_collision();
        tick();
        a_i_req = 1'b1; a_i_addr = 9'h008;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 9'h010; a_d_funct3 = 3'b010;
        sb.push_back('{1'b1, pat(9'h010)});
        sb.push_back('{1'b0, pat(9'h008)});
        @(negedge clk);
        checks++;
        if (a_d_gnt !== 1'b1 || a_i_gnt !== 1'b0 || a_m_addr !== 9'h010) begin
            errors++;
            $display("FAIL collision_t0: d_gnt=%b i_gnt=%b m_addr=%h, expected 1 0 010", a_d_gnt, a_i_gnt, a_m_addr);
        end
        tick();
        a_d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_i_gnt !== 1'b1 || a_d_gnt !== 1'b0 || a_d_rvalid !== 1'b1 || a_m_addr !== 9'h008) begin
            errors++;
            $display("FAIL collision_t1: i_gnt=%b d_gnt=%b d_rvalid=%b m_addr=%h, expected 1 0 1 008",
                     a_i_gnt, a_d_gnt, a_d_rvalid, a_m_addr);
        end
        tick();
        a_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_i_rvalid !== 1'b1 || a_i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL collision_t2: i_rvalid=%b i_gnt=%b, expected 1 0", a_i_rvalid, a_i_gnt);
        end
    endtask

    task automatic test_starvation();
        bit exp_i [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            tick();
            a_i_req = 1'b1; a_i_addr = 9'h040;
            a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 9'(9'h080 + k);
            sb.push_back('{!exp_i[k], exp_i[k] ? pat(9'h040) : pat(9'(9'h080 + k))});
            @(negedge clk);
            checks++;
            if (a_i_gnt !== exp_i[k] || a_d_gnt !== !exp_i[k]) begin
                errors++;
                $display("FAIL starve_grant%0d: i_gnt=%b d_gnt=%b, expected %b %b",
                         k, a_i_gnt, a_d_gnt, exp_i[k], !exp_i[k]);
            end
        end
        tick();
        a_i_req = 1'b0; a_d_req = 1'b0;
        @(negedge clk);
        tick();
    endtask

    task automatic test_store();
        a_i_req = 1'b1; a_i_addr = 9'h030;
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 9'h020;
        a_d_wdata = 32'hDEADBEEF; a_d_funct3 = 3'b010;
        @(negedge clk);
        checks++;
        if (a_d_gnt !== 1'b1 || a_i_gnt !== 1'b0 || a_m_we !== 1'b1 || a_m_addr !== 9'h020 ||
            a_m_wdata !== 32'hDEADBEEF || a_m_funct3 !== 3'b010 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL store_issue: d_gnt=%b i_gnt=%b m_we=%b m_addr=%h m_wdata=%h f3=%b busy=%b, expected 1 0 1 020 deadbeef 010 0",
                     a_d_gnt, a_i_gnt, a_m_we, a_m_addr, a_m_wdata, a_m_funct3, a_busy);
        end
        tick();
        a_d_req = 1'b0; a_d_we = 1'b0;
        sb.push_back('{1'b0, pat(9'h030)});
        @(negedge clk);
        checks++;
        if (a_i_gnt !== 1'b1 || a_d_rvalid !== 1'b0 || a_busy !== 1'b0 || a_m_we !== 1'b0) begin
            errors++;
            $display("FAIL store_next: i_gnt=%b d_rvalid=%b busy=%b m_we=%b, expected 1 0 0 0",
                     a_i_gnt, a_d_rvalid, a_busy, a_m_we);
        end
        tick();
        a_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL store_after: busy=%b d_rvalid=%b, expected 1 0", a_busy, a_d_rvalid);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        // I read, flush one cycle after grant: busy T1..T3, no i_rvalid
        tick();
        b_i_req = 1'b1; b_i_addr = 9'h044;
        @(negedge clk);
        checks++;
        if (b_i_gnt !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_grant: i_gnt=%b busy=%b, expected 1 0", b_i_gnt, b_busy);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_i_req = 1'b0; b_flush = (k == 1);
            @(negedge clk);
            checks++;
            if (b_busy !== (k <= 3) || b_i_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL flush_kill_t%0d: busy=%b i_rvalid=%b, expected %b 0", k, b_busy, b_i_rvalid, k <= 3);
            end
        end
        // D read with flush: still delivered at T3
        tick();
        b_flush = 1'b0; b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 9'h048;
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_d_req = 1'b0; b_flush = (k == 1);
            @(negedge clk);
            checks++;
            if (b_d_rvalid !== (k == 3) || (k == 3 && b_d_rdata !== pat(9'h048))) begin
                errors++;
                $display("FAIL flush_dread_t%0d: d_rvalid=%b d_rdata=%h, expected %b %h",
                         k, b_d_rvalid, b_d_rdata, k == 3, pat(9'h048));
            end
        end
        // I read with flush in its grant cycle: killed
        tick();
        b_flush = 1'b1; b_i_req = 1'b1; b_i_addr = 9'h04C;
        @(negedge clk);
        checks++;
        if (b_i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_gnt_cycle: i_gnt=%b, expected 1", b_i_gnt);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            b_flush = 1'b0; b_i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (b_i_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL flush_gnt_kill_t%0d: i_rvalid=%b, expected 0", k, b_i_rvalid);
            end
        end
        // Plain I read, delivered at T3
        tick();
        b_i_req = 1'b1; b_i_addr = 9'h054;
        for (int k = 1; k <= 3; k++) begin
            tick();
            b_i_req = 1'b0;
            @(negedge clk);
            checks++;
            if (b_i_rvalid !== (k == 3) || (k == 3 && b_i_rdata !== pat(9'h054))) begin
                errors++;
                $display("FAIL lat3_fetch_t%0d: i_rvalid=%b i_rdata=%h, expected %b %h",
                         k, b_i_rvalid, b_i_rdata, k == 3, pat(9'h054));
            end
        end
        // D read aborted by reset at T1
        tick();
        b_d_req = 1'b1; b_d_addr = 9'h050;
        @(negedge clk);
        checks++;
        if (b_d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort_gnt: d_gnt=%b, expected 1", b_d_gnt);
        end
        tick();
        b_d_req = 1'b0; b_reset = 1'b1; b_i_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({b_i_gnt, b_d_gnt, b_m_req, b_i_rvalid, b_d_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_abort_t1: gnt/mreq/rvalid=%b, expected 00000",
                     {b_i_gnt, b_d_gnt, b_m_req, b_i_rvalid, b_d_rvalid});
        end
        tick();
        b_reset = 1'b0; b_i_req = 1'b0;
        @(negedge clk);
        checks++;
        if (b_busy !== 1'b0 || b_i_rdata !== 32'd0 || b_d_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort_t2: busy=%b i_rdata=%h d_rdata=%h, expected 0 0 0", b_busy, b_i_rdata, b_d_rdata);
        end
        for (int k = 3; k <= 6; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (b_d_rvalid !== 1'b0 || b_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort_t%0d: d_rvalid=%b busy=%b, expected 0 0", k, b_d_rvalid, b_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_store();
        test_flush_reset();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
